// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a one-entry valid/ready output buffer.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   din        - asynchronous serial line, idles high
//   dout       - received word, LSB = first bit on the line
//   dout_valid - dout and its flags hold a word
//   dout_ready - consumer accepts the word on dout_valid && dout_ready
//   parity_err - parity mismatch for the word in dout
//   frame_err  - a stop bit was sampled low for the word in dout
//   overrun    - one-cycle pulse when a completed frame is dropped
//   busy       - receiver is not in IDLE
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  // Index counter is shared by data and stop phases; STOP_BITS <= 2 < DATA_BITS.
  localparam int unsigned IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  // Synchroniser and receive-side state
  logic                 sync1_q, sync2_q;
  logic                 din_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 complete_c;

  // Output buffer
  logic [DATA_BITS-1:0] dout_q;
  logic                 dout_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

  assign din_s = sync2_q;

  // Next-state and datapath updates; bit_cnt clears on every sample and state change
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + CW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    complete_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!din_s) begin
          state_d   = S_START;
          idx_d     = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          state_d   = din_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          shift_d   = {din_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          par_err_d = ((^shift_q) ^ din_s) != ODD_PAR;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          frm_err_d = frm_err_q | ~din_s;
          if (idx_q == STOP_LAST) begin
            idx_d      = '0;
            complete_c = 1'b1;
            // A low final stop bit means the line may be held low: wait it out.
            state_d    = din_s ? S_IDLE : S_BREAK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_BREAK: begin
        bit_cnt_d = '0;
        if (din_s) state_d = S_IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State, synchroniser and output buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q   <= din;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      busy_q    <= (state_d != S_IDLE);
      overrun_q <= 1'b0;

      if (complete_c) begin
        // Load when the buffer is empty or being drained this cycle; otherwise drop.
        if (!dout_valid_q || dout_ready) begin
          dout_q       <= shift_d;
          parity_err_q <= par_err_d;
          frame_err_q  <= frm_err_d;
          dout_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 instance and a 7E1 instance.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din8, din7, rdy8, rdy7;
  logic [7:0] dout8;
  logic [6:0] dout7;
  logic       v8, pe8, fe8, ov8, busy8;
  logic       v7, pe7, fe7, ov7, busy7;

  word_t exp8_q[$], obs8_q[$], exp7_q[$], obs7_q[$];
  word_t mon_w8, mon_w7;
  int    ovr8 = 0, vhigh8 = 0;
  int    errors = 0, checks = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .din(din8), .dout(dout8), .dout_valid(v8), .dout_ready(rdy8),
    .parity_err(pe8), .frame_err(fe8), .overrun(ov8), .busy(busy8)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .din(din7), .dout(dout7), .dout_valid(v7), .dout_ready(rdy7),
    .parity_err(pe7), .frame_err(fe7), .overrun(ov7), .busy(busy7)
  );

  // Record accepted words and overrun/valid activity, away from the active edge
  always @(negedge clk) begin
    if (v8 && rdy8) begin
      mon_w8.data = 9'(dout8);
      mon_w8.perr = pe8;
      mon_w8.ferr = fe8;
      obs8_q.push_back(mon_w8);
    end
    if (v7 && rdy7) begin
      mon_w7.data = 9'(dout7);
      mon_w7.perr = pe7;
      mon_w7.ferr = fe7;
      obs7_q.push_back(mon_w7);
    end
    if (ov8) ovr8++;
    if (v8) vhigh8++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) din7 = bits[i];
      else     din8 = bits[i];
      tick(CPB);
    end
  endtask

  function automatic logic [11:0] frame8(input logic [7:0] d, input logic stop);
    return {2'b11, stop, d, 1'b0};
  endfunction

  function automatic logic [11:0] frame7(input logic [6:0] d, input logic par);
    return {2'b11, 1'b1, par, d, 1'b0};
  endfunction

  function automatic word_t mkw(input logic [8:0] d, input logic p, input logic f);
    word_t w;
    w.data = d;
    w.perr = p;
    w.ferr = f;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL reset_dout8: got %h expected 00", dout8); end
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b expected 0", v8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    checks++; if ({pe8, fe8, ov8} !== 3'b000) begin errors++; $display("FAIL reset_flags8: got %b expected 000", {pe8, fe8, ov8}); end
    checks++; if ({v7, busy7, pe7, fe7, ov7} !== 5'b0) begin errors++; $display("FAIL reset_ctl7: got %b expected 00000", {v7, busy7, pe7, fe7, ov7}); end
    checks++; if (dout7 !== 7'h00) begin errors++; $display("FAIL reset_dout7: got %h expected 00", dout7); end
    rst = 1'b0;
    tick(2 * CPB);
  endtask

  task automatic test_8n1();
    int    vh0;
    word_t e, o;
    rdy8 = 1'b1;
    vh0  = vhigh8;
    exp8_q.push_back(mkw(9'h047, 1'b0, 1'b0));
    drive(1'b0, frame8(8'h47, 1'b1), 10);
    din8 = 1'b1;
    tick(2 * CPB);
    checks++; if (obs8_q.size() !== 1) begin errors++; $display("FAIL 8n1_count: got %0d words expected 1", obs8_q.size()); end
    while (exp8_q.size() > 0 && obs8_q.size() > 0) begin
      e = exp8_q.pop_front(); o = obs8_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL 8n1_word: got %h expected %h", o, e); end
    end
    checks++; if (vhigh8 - vh0 !== 1) begin errors++; $display("FAIL 8n1_valid_width: got %0d cycles expected 1", vhigh8 - vh0); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL 8n1_idle_busy: got %b expected 0", busy8); end
    exp8_q.delete(); obs8_q.delete();
  endtask

  task automatic test_parity();
    word_t e, o;
    rdy7 = 1'b1;
    // 0x47 has four ones: even parity bit should be 0
    exp7_q.push_back(mkw(9'h047, 1'b1, 1'b0));
    drive(1'b1, frame7(7'h47, 1'b1), 11);
    exp7_q.push_back(mkw(9'h047, 1'b0, 1'b0));
    drive(1'b1, frame7(7'h47, 1'b0), 11);
    // 0x23 has three ones: even parity bit should be 1
    exp7_q.push_back(mkw(9'h023, 1'b0, 1'b0));
    drive(1'b1, frame7(7'h23, 1'b1), 11);
    din7 = 1'b1;
    tick(2 * CPB);
    checks++; if (obs7_q.size() !== 3) begin errors++; $display("FAIL parity_count: got %0d words expected 3", obs7_q.size()); end
    while (exp7_q.size() > 0 && obs7_q.size() > 0) begin
      e = exp7_q.pop_front(); o = obs7_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL parity_word: got %h expected %h", o, e); end
    end
    exp7_q.delete(); obs7_q.delete();
  endtask

  task automatic test_break();
    word_t e, o;
    rdy8 = 1'b1;
    exp8_q.push_back(mkw(9'h0A5, 1'b0, 1'b1));
    drive(1'b0, frame8(8'hA5, 1'b0), 10);
    tick(39 * CPB);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL break_busy_low: got %b expected 1", busy8); end
    checks++; if (obs8_q.size() !== 1) begin errors++; $display("FAIL break_count: got %0d words expected 1", obs8_q.size()); end
    while (exp8_q.size() > 0 && obs8_q.size() > 0) begin
      e = exp8_q.pop_front(); o = obs8_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL break_word: got %h expected %h", o, e); end
    end
    din8 = 1'b1;
    tick(6);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL break_release_busy: got %b expected 0", busy8); end
    tick(2 * CPB);
    checks++; if (obs8_q.size() !== 0) begin errors++; $display("FAIL break_extra: got %0d words expected 0", obs8_q.size()); end
    exp8_q.delete(); obs8_q.delete();
  endtask

  task automatic test_glitch();
    int vh0;
    vh0  = vhigh8;
    din8 = 1'b0;
    tick(4);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy8); end
    din8 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (busy8 === 1'b0) break;
      tick(1);
    end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 0 within 12 cycles", busy8); end
    tick(2 * CPB);
    checks++; if (vhigh8 - vh0 !== 0) begin errors++; $display("FAIL glitch_no_word: got %0d valid cycles expected 0", vhigh8 - vh0); end
    obs8_q.delete();
  endtask

  task automatic test_back_to_back();
    int    ov0;
    word_t e, o;
    rdy8 = 1'b0;
    ov0  = ovr8;
    exp8_q.push_back(mkw(9'h011, 1'b0, 1'b0));
    drive(1'b0, frame8(8'h11, 1'b1), 10);
    drive(1'b0, frame8(8'h22, 1'b1), 10);
    drive(1'b0, frame8(8'h33, 1'b1), 10);
    din8 = 1'b1;
    tick(2 * CPB);
    checks++; if (ovr8 - ov0 !== 2) begin errors++; $display("FAIL b2b_overruns: got %0d expected 2", ovr8 - ov0); end
    checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL b2b_held_valid: got %b expected 1", v8); end
    checks++; if (dout8 !== 8'h11) begin errors++; $display("FAIL b2b_held_dout: got %h expected 11", dout8); end
    rdy8 = 1'b1;
    tick(1);
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %b expected 0", v8); end
    tick(2);
    checks++; if (obs8_q.size() !== 1) begin errors++; $display("FAIL b2b_count: got %0d words expected 1", obs8_q.size()); end
    while (exp8_q.size() > 0 && obs8_q.size() > 0) begin
      e = exp8_q.pop_front(); o = obs8_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_word: got %h expected %h", o, e); end
    end
    exp8_q.delete(); obs8_q.delete();
  endtask

  task automatic test_reset_mid();
    word_t e, o;
    rdy8 = 1'b1;
    drive(1'b0, frame8(8'h5A, 1'b1), 5);
    rst = 1'b1;
    tick(1);
    rst  = 1'b0;
    din8 = 1'b1;
    checks++; if ({busy8, v8} !== 2'b00) begin errors++; $display("FAIL rstmid_state: got %b expected 00", {busy8, v8}); end
    tick(2 * CPB);
    exp8_q.push_back(mkw(9'h03C, 1'b0, 1'b0));
    drive(1'b0, frame8(8'h3C, 1'b1), 10);
    din8 = 1'b1;
    tick(2 * CPB);
    checks++; if (obs8_q.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d words expected 1", obs8_q.size()); end
    while (exp8_q.size() > 0 && obs8_q.size() > 0) begin
      e = exp8_q.pop_front(); o = obs8_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rstmid_word: got %h expected %h", o, e); end
    end
    exp8_q.delete(); obs8_q.delete();
  endtask

  initial begin
    rst  = 1'b1;
    din8 = 1'b1;
    din7 = 1'b1;
    rdy8 = 1'b1;
    rdy7 = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
